// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the SoPC bus fabric.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Bit positions in the one-hot data-phase select; all-zero means no owner.
  localparam int unsigned SLV_RAM = 0;
  localparam int unsigned SLV_PIO = 1;
  localparam int unsigned SLV_APB = 2;
  localparam int unsigned SLV_DEF = 3;
  localparam int unsigned NUM_SLV = 4;

  typedef enum logic [1:0] {
    DEF_IDLE = 2'b00,
    DEF_ERR1 = 2'b01,
    DEF_ERR2 = 2'b10
  } def_state_e;

  // True for transfers that require a real response (NONSEQ or SEQ).
  function automatic logic is_transfer(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR for unmapped transfers, plus a saturating
// count of how many such transfers were seen.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             sel,
  input  logic             hready,
  output logic             hreadyout,
  output logic             hresp,
  output logic [CNT_W-1:0] unmapped_cnt
);

  def_state_e state_q, state_d;
  logic       enter_err;

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= DEF_IDLE;
    else          state_q <= state_d;
  end

  // Next state and response outputs; ERR2 is itself an accepting cycle.
  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state_q)
      DEF_IDLE: begin
        if (sel && hready) state_d = DEF_ERR1;
      end
      DEF_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = DEF_ERR2;
      end
      DEF_ERR2: begin
        hresp   = HRESP_ERROR;
        state_d = (sel && hready) ? DEF_ERR1 : DEF_IDLE;
      end
      default: state_d = DEF_IDLE;
    endcase
    enter_err = (state_d == DEF_ERR1) && (state_q != DEF_ERR1);
  end

  // Saturating count of unmapped transfers entering the error response.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)
      unmapped_cnt <= '0;
    else if (enter_err && (unmapped_cnt != '1))
      unmapped_cnt <= unmapped_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite data-phase response mux with integrated default slave.
module ahb_slave_mux
  import ahb_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic [1:0]       htrans,
  input  logic             ram_hsel,
  input  logic             pio_hsel,
  input  logic             apbsys_hsel,
  input  logic             ram_hreadyout,
  input  logic             ram_hresp,
  input  logic [DW-1:0]    ram_hrdata,
  input  logic             pio_hreadyout,
  input  logic             pio_hresp,
  input  logic [DW-1:0]    pio_hrdata,
  input  logic             apbsys_hreadyout,
  input  logic             apbsys_hresp,
  input  logic [DW-1:0]    apbsys_hrdata,
  output logic             hready,
  output logic             hresp,
  output logic [DW-1:0]    hrdata,
  output logic [CNT_W-1:0] unmapped_cnt
);

  logic [NUM_SLV-1:0] dsel_q, dsel_d;
  logic               unmapped_sel;
  logic               def_hreadyout;
  logic               def_hresp;

  // Address-phase decode into a one-hot owner (all-zero = no owner).
  always_comb begin
    dsel_d       = '0;
    unmapped_sel = 1'b0;
    if (ram_hsel)             dsel_d[SLV_RAM] = 1'b1;
    else if (pio_hsel)        dsel_d[SLV_PIO] = 1'b1;
    else if (apbsys_hsel)     dsel_d[SLV_APB] = 1'b1;
    else if (is_transfer(htrans)) begin
      dsel_d[SLV_DEF] = 1'b1;
      unmapped_sel    = 1'b1;
    end
  end

  // Data-phase owner, loaded only on accepting edges.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)    dsel_q <= '0;
    else if (hready) dsel_q <= dsel_d;
  end

  // Return-path mux; no owner gives a zero-wait OKAY with zero data.
  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    hrdata = '0;
    if (dsel_q[SLV_RAM]) begin
      hready = ram_hreadyout;
      hresp  = ram_hresp;
      hrdata = ram_hrdata;
    end else if (dsel_q[SLV_PIO]) begin
      hready = pio_hreadyout;
      hresp  = pio_hresp;
      hrdata = pio_hrdata;
    end else if (dsel_q[SLV_APB]) begin
      hready = apbsys_hreadyout;
      hresp  = apbsys_hresp;
      hrdata = apbsys_hrdata;
    end else if (dsel_q[SLV_DEF]) begin
      hready = def_hreadyout;
      hresp  = def_hresp;
    end
  end

  ahb_default_slave #(
    .CNT_W(CNT_W)
  ) u_default_slave (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .sel         (unmapped_sel),
    .hready      (hready),
    .hreadyout   (def_hreadyout),
    .hresp       (def_hresp),
    .unmapped_cnt(unmapped_cnt)
  );

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Self-checking bench for ahb_slave_mux: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_ahb_slave_mux;

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 8;

  logic             hclk = 1'b0;
  logic             hresetn;
  logic [1:0]       htrans;
  logic             ram_hsel, pio_hsel, apbsys_hsel;
  logic             ram_hreadyout, ram_hresp;
  logic [DW-1:0]    ram_hrdata;
  logic             pio_hreadyout, pio_hresp;
  logic [DW-1:0]    pio_hrdata;
  logic             apbsys_hreadyout, apbsys_hresp;
  logic [DW-1:0]    apbsys_hrdata;
  logic             hready, hresp;
  logic [DW-1:0]    hrdata;
  logic [CNT_W-1:0] unmapped_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [41:0] got, exp;

  ahb_slave_mux #(
    .DW(DW),
    .CNT_W(CNT_W)
  ) dut (
    .hclk            (hclk),
    .hresetn         (hresetn),
    .htrans          (htrans),
    .ram_hsel        (ram_hsel),
    .pio_hsel        (pio_hsel),
    .apbsys_hsel     (apbsys_hsel),
    .ram_hreadyout   (ram_hreadyout),
    .ram_hresp       (ram_hresp),
    .ram_hrdata      (ram_hrdata),
    .pio_hreadyout   (pio_hreadyout),
    .pio_hresp       (pio_hresp),
    .pio_hrdata      (pio_hrdata),
    .apbsys_hreadyout(apbsys_hreadyout),
    .apbsys_hresp    (apbsys_hresp),
    .apbsys_hrdata   (apbsys_hrdata),
    .hready          (hready),
    .hresp           (hresp),
    .hrdata          (hrdata),
    .unmapped_cnt    (unmapped_cnt)
  );

  always #5 hclk = ~hclk;

  task automatic drive(input logic [1:0] tr, input logic r, input logic p, input logic a);
    htrans      = tr;
    ram_hsel    = r;
    pio_hsel    = p;
    apbsys_hsel = a;
  endtask

  task automatic slaves_okay();
    ram_hreadyout = 1'b1; ram_hresp = 1'b0; ram_hrdata = '0;
    pio_hreadyout = 1'b1; pio_hresp = 1'b0; pio_hrdata = '0;
    apbsys_hreadyout = 1'b1; apbsys_hresp = 1'b0; apbsys_hrdata = '0;
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    slaves_okay();
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    slaves_okay();
    #2;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'h0, 8'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL reset_low got=%h want=%h", got, exp); end
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    repeat (3) @(negedge hclk);
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt};
    checks++; if (got !== exp) begin errors++; $display("FAIL reset_release got=%h want=%h", got, exp); end
  endtask

  task automatic test_ram_wait();
    @(negedge hclk);
    drive(2'b10, 1'b1, 1'b0, 1'b0);
    @(negedge hclk);
    ram_hreadyout = 1'b0; ram_hrdata = 32'h0BAD_0BAD;
    pio_hrdata = 32'h1111_0000;
    drive(2'b10, 1'b0, 1'b1, 1'b0);
    for (int w = 0; w < 2; w++) begin
      if (w > 0) @(negedge hclk);
      #1;
      got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b0, 1'b0, 32'h0BAD_0BAD, 8'd0};
      checks++; if (got !== exp) begin errors++; $display("FAIL ram_wait%0d got=%h want=%h", w, got, exp); end
    end
    @(negedge hclk);
    ram_hreadyout = 1'b1; ram_hrdata = 32'h1234_5678;
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'h1234_5678, 8'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL ram_data got=%h want=%h", got, exp); end
    @(negedge hclk);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'h1111_0000, 8'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL pio_after_wait got=%h want=%h", got, exp); end
    @(negedge hclk);
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'h0, 8'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL ram_wait_none got=%h want=%h", got, exp); end
  endtask

  task automatic test_back_to_back();
    slaves_okay();
    @(negedge hclk);
    drive(2'b10, 1'b1, 1'b0, 1'b0);
    @(negedge hclk);
    ram_hrdata = 32'h1234_5678;
    drive(2'b10, 1'b0, 1'b1, 1'b0);
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'h1234_5678, 8'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_ram got=%h want=%h", got, exp); end
    @(negedge hclk);
    pio_hrdata = 32'hA5A5_0001;
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'hA5A5_0001, 8'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_pio got=%h want=%h", got, exp); end
  endtask

  task automatic test_idle_none();
    slaves_okay();
    ram_hrdata = 32'hFFFF_FFFF; pio_hrdata = 32'hFFFF_FFFF; apbsys_hrdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge hclk);
      drive((k % 2 == 0) ? 2'b00 : 2'b01, 1'b0, 1'b0, 1'b0);
      @(negedge hclk);
      #1;
      got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'h0, 8'd0};
      checks++; if (got !== exp) begin errors++; $display("FAIL idle_none%0d got=%h want=%h", k, got, exp); end
    end
    drive(2'b00, 1'b1, 1'b0, 1'b0);
    @(negedge hclk);
    ram_hrdata = 32'h0000_0077;
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'h0000_0077, 8'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL idle_ram_sel got=%h want=%h", got, exp); end
    @(negedge hclk);
  endtask

  task automatic test_unmapped();
    int unsigned want_cnt;
    slaves_okay();
    drive(2'b10, 1'b0, 1'b0, 1'b0);
    @(negedge hclk);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b0, 1'b1, 32'h0, 8'd1};
    checks++; if (got !== exp) begin errors++; $display("FAIL unmapped_err1 got=%h want=%h", got, exp); end
    @(negedge hclk);
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b1, 32'h0, 8'd1};
    checks++; if (got !== exp) begin errors++; $display("FAIL unmapped_err2 got=%h want=%h", got, exp); end
    @(negedge hclk);
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'h0, 8'd1};
    checks++; if (got !== exp) begin errors++; $display("FAIL unmapped_after got=%h want=%h", got, exp); end
    drive(2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 600; i++) begin
      @(negedge hclk);
      want_cnt = 1 + (i + 1) / 2;
      if (want_cnt > 255) want_cnt = 255;
      got = {hready, hresp, hrdata, unmapped_cnt};
      exp = {(i % 2 == 0), 1'b1, 32'h0, 8'(want_cnt)};
      checks++; if (got !== exp) begin errors++; $display("FAIL unmapped_b2b%0d got=%h want=%h", i, got, exp); end
    end
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge hclk);
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'h0, 8'hFF};
    checks++; if (got !== exp) begin errors++; $display("FAIL unmapped_sat got=%h want=%h", got, exp); end
  endtask

  task automatic test_reset_mid();
    drive(2'b10, 1'b0, 1'b0, 1'b0);
    @(negedge hclk);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b0, 1'b1, 32'h0, 8'hFF};
    checks++; if (got !== exp) begin errors++; $display("FAIL rst_mid_err1 got=%h want=%h", got, exp); end
    #1 hresetn = 1'b0;
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'h0, 8'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL rst_in_err1 got=%h want=%h", got, exp); end
    @(negedge hclk);
    hresetn = 1'b1;
    drive(2'b10, 1'b0, 1'b0, 1'b1);
    @(negedge hclk);
    apbsys_hreadyout = 1'b0; apbsys_hresp = 1'b1; apbsys_hrdata = 32'hDEAD_BEEF;
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b0, 1'b1, 32'hDEAD_BEEF, 8'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL apb_wait got=%h want=%h", got, exp); end
    #1 hresetn = 1'b0;
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'h0, 8'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL rst_in_apb got=%h want=%h", got, exp); end
    @(negedge hclk);
    hresetn = 1'b1;
    drive(2'b10, 1'b1, 1'b0, 1'b0);
    @(negedge hclk);
    ram_hreadyout = 1'b1; ram_hresp = 1'b0; ram_hrdata = 32'hCAFE_0001;
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    got = {hready, hresp, hrdata, unmapped_cnt}; exp = {1'b1, 1'b0, 32'hCAFE_0001, 8'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL after_rst_ram got=%h want=%h", got, exp); end
    slaves_okay();
  endtask

  // Reference model: owner 0 RAM, 1 PIO, 2 APB, 3 default slave, 4 nobody;
  // err_cycle counts which cycle of the two-cycle error is showing.
  task automatic test_random();
    int owner, err_cycle, mcnt;
    logic e_rdy, e_resp;
    logic [DW-1:0] e_data;
    do_reset();
    owner = 4; err_cycle = 0; mcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge hclk);
      htrans = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: drive(htrans, 1'b0, 1'b0, 1'b0);
        1: drive(htrans, 1'b1, 1'b0, 1'b0);
        2: drive(htrans, 1'b0, 1'b1, 1'b0);
        default: drive(htrans, 1'b0, 1'b0, 1'b1);
      endcase
      if ($urandom_range(0, 15) == 0) drive(htrans, 1'($urandom), 1'($urandom), 1'($urandom));
      ram_hreadyout = ($urandom_range(0, 3) != 0); ram_hresp = ($urandom_range(0, 7) == 0);
      pio_hreadyout = ($urandom_range(0, 3) != 0); pio_hresp = ($urandom_range(0, 7) == 0);
      apbsys_hreadyout = ($urandom_range(0, 3) != 0); apbsys_hresp = ($urandom_range(0, 7) == 0);
      ram_hrdata = $urandom; pio_hrdata = $urandom; apbsys_hrdata = $urandom;
      #1;
      case (owner)
        0: begin e_rdy = ram_hreadyout; e_resp = ram_hresp; e_data = ram_hrdata; end
        1: begin e_rdy = pio_hreadyout; e_resp = pio_hresp; e_data = pio_hrdata; end
        2: begin e_rdy = apbsys_hreadyout; e_resp = apbsys_hresp; e_data = apbsys_hrdata; end
        3: begin e_rdy = (err_cycle == 2); e_resp = 1'b1; e_data = '0; end
        default: begin e_rdy = 1'b1; e_resp = 1'b0; e_data = '0; end
      endcase
      got = {hready, hresp, hrdata, unmapped_cnt};
      exp = {e_rdy, e_resp, e_data, 8'(mcnt)};
      checks++; if (got !== exp) begin errors++; $display("FAIL random%0d got=%h want=%h", n, got, exp); end
      @(posedge hclk);
      if (owner == 3 && err_cycle == 1) begin
        err_cycle = 2;
      end else if (e_rdy) begin
        if (ram_hsel) owner = 0;
        else if (pio_hsel) owner = 1;
        else if (apbsys_hsel) owner = 2;
        else if (htrans >= 2'b10) owner = 3;
        else owner = 4;
        if (owner == 3) begin
          err_cycle = 1;
          if (mcnt < 255) mcnt++;
        end else begin
          err_cycle = 0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram_wait();
    test_back_to_back();
    test_idle_none();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mux.md
Name: ahb_slave_mux

Overview:
- Data-phase response multiplexer for the SoPC AHB-Lite bus, directly downstream of the address decoder.
- Consumes the three decoder selects (RAM 0x1000xxxx, PIO 0x2000xxxx, APB subsystem 0x3000xxxx) during the address phase and registers which slave owns the following data phase.
- In the data phase, routes that slave's hrdata/hreadyout/hresp back to the PicoRV32 AHB master.
- Contains an integrated default slave that returns a two-cycle ERROR for any NONSEQ/SEQ transfer that hits no slave.

Parameters:
- DW, 32, data bus width.
- CNT_W, 8, width of saturating unmapped-access counter.

Ports:
- hclk  input  1  bus clock.
- hresetn  input  1  reset, asynchronous, active-low.
- htrans  input  2  master transfer type (address phase).
- ram_hsel  input  1  decoder select, RAM.
- pio_hsel  input  1  decoder select, PIO.
- apbsys_hsel  input  1  decoder select, APB subsystem.
- ram_hreadyout  input  1  RAM ready.
- ram_hresp  input  1  RAM response.
- ram_hrdata  input  DW  RAM read data.
- pio_hreadyout  input  1  PIO ready.
- pio_hresp  input  1  PIO response.
- pio_hrdata  input  DW  PIO read data.
- apbsys_hreadyout  input  1  APB bridge ready.
- apbsys_hresp  input  1  APB bridge response.
- apbsys_hrdata  input  DW  APB bridge read data.
- hready  output  1  bus ready to master; also fanned out to all slaves' hready input.
- hresp  output  1  response to master (0 OKAY, 1 ERROR).
- hrdata  output  DW  read data to master.
- unmapped_cnt  output  CNT_W  count of unmapped accesses, saturating.

Behaviour:
- Single clock hclk. hresetn is asynchronous assert, synchronous deassert, as provided by the system reset block.
- Address phase accepted on a rising hclk edge where hready==1. Only at such edges:
  - Data-phase select register dsel (one-hot: RAM, PIO, APB, DEF, or NONE) loads from the current inputs.
  - Priority: ram_hsel > pio_hsel > apbsys_hsel. Multiple selects never occur from the decoder; priority is defined only for determinism.
  - If htrans[1]==1 and no select is active -> DEF.
  - If htrans[1]==0 and no select is active -> NONE.
  - A slave select is registered even with htrans IDLE; the slave itself returns zero-wait OKAY.
- When hready==0, dsel holds.
- Output mux (combinational from dsel):
  - RAM/PIO/APB: pass that slave's hreadyout/hresp/hrdata.
  - NONE: hready=1, hresp=0, hrdata=0.
  - DEF: driven by the default-slave FSM.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 on the accepted edge that loads dsel=DEF.
  - ERR1: hready=0, hresp=1, hrdata=0. Always -> ERR2 next cycle.
  - ERR2: hready=1, hresp=1, hrdata=0. Next state: ERR1 if the accepted address is again unmapped NONSEQ/SEQ, else IDLE.
  - The ERR2 edge is an accepting edge, so back-to-back unmapped transfers produce ERR1,ERR2,ERR1,ERR2.
- unmapped_cnt increments by 1 on each IDLE/ERR2 -> ERR1 transition and saturates at all-ones (no wrap).
- Reset values: dsel=NONE, FSM=IDLE, unmapped_cnt=0. Hence hready=1, hresp=0, hrdata=0.
- Reset mid-transfer: all state returns to reset values immediately and asynchronously. Any wait-stated slave data phase is abandoned, and hready reads 1 while hresetn is low.
- Latency: zero added cycles. Mux outputs are combinational from the registered dsel plus slave outputs; the only registered element in the return path is dsel.
- Slave ERROR (two-cycle) is passed through transparently; the mux does not count it.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11).
  - HRESP_OKAY/HRESP_ERROR.
  - Slave index constants (RAM 0, PIO 1, APB 2, DEF 3).
  - Default-slave state encoding.
- One natural sub-module, ahb_default_slave:
  - Contains the FSM and the saturating counter.
  - Inputs: hclk, hresetn, sel (accepted unmapped NONSEQ/SEQ), hready.
  - Outputs: hreadyout, hresp, unmapped_cnt.

Test Plan:
- Reset, then release with no traffic -> hready=1, hresp=0, hrdata=0, unmapped_cnt=0.
- NONSEQ read with ram_hsel=1, RAM responds with 2 wait states then hrdata=32'h1234_5678 -> hready low for 2 cycles, then hrdata=32'h1234_5678, hresp=0. A pio_hsel address presented during the waits is not latched until hready=1.
- Back-to-back NONSEQ RAM then PIO (pio_hrdata=32'hA5A5_0001) -> data phases return the RAM data then 32'hA5A5_0001 in consecutive cycles, with no bubble.
- NONSEQ with no select -> one cycle hready=0/hresp=1, then hready=1/hresp=1, and unmapped_cnt=1. Repeat 300 times back-to-back -> unmapped_cnt saturates at 8'hFF.
- IDLE htrans with no select -> NONE: hready=1, hresp=0, and unmapped_cnt unchanged.
- Assert hresetn low during ERR1 and during an APB wait state -> hready=1, hresp=0, and unmapped_cnt=0 immediately (same cycle, asynchronous). The next transfer after release decodes normally.
